// File: rtl/prim_shift_seq_pkg.sv
// Shared types and sizing helpers for the prim_shift_seq frame sequencer.
package prim_shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_seq_state_e;

  // Bit counter must be able to hold the value WIDTH.
  function automatic int bitcnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/prim_shift_seq_tick.sv
// Bit-period divider: fires tick_o when the count reaches period_i, then wraps.
// Only used when PRIM_SHIFT_SEQ_DIV_EN is defined.
module prim_shift_seq_tick #(
  parameter int DIVW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic [DIVW-1:0] period_i,
  output logic            tick_o
);

  logic [DIVW-1:0] cnt_r;

  // Tick counter, held at zero while cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_r <= '0;
    end else if (cnt_r == period_i) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIVW'(1);
    end
  end

  assign tick_o = ~clr_i & (cnt_r == period_i);

endmodule

// File: rtl/prim_shift_seq.sv
// Serial frame sequencer: shifts a parallel word out MSB-first while capturing serial_i.
// Optional bit-period divider is enabled with `define PRIM_SHIFT_SEQ_DIV_EN.
module prim_shift_seq
  import prim_shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIVW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic [DIVW-1:0]  div_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic             shift_o,
  output logic             busy_o,
  output logic             rx_valid_o,
  output logic [WIDTH-1:0] rx_data_o
);

  localparam int BW = bitcnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  shift_seq_state_e state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] rx_data_r;
  logic [BW-1:0]    bitcnt_r;
  logic             rx_valid_r;
  logic             busy_r;
  logic             ready_r;
  logic             accept_s;
  logic             tick_s;

  assign accept_s = tx_valid_i & ready_r;

`ifdef PRIM_SHIFT_SEQ_DIV_EN
  logic [DIVW-1:0] div_q;
  logic            clr_s;

  // Divider value is frozen for the whole frame at the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else if (accept_s) begin
      div_q <= div_i;
    end
  end

  assign clr_s = (state_r != SHIFT);

  prim_shift_seq_tick #(
    .DIVW(DIVW)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr_s),
    .period_i (div_q),
    .tick_o   (tick_s)
  );
`else
  logic unused_div_s;

  assign unused_div_s = ^div_i;
  assign tick_s       = (state_r == SHIFT);
`endif

  // Frame FSM with shift register, bit counter and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      bitcnt_r   <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          ready_r <= 1'b1;
          if (accept_s) begin
            shreg_r  <= tx_data_i;
            bitcnt_r <= '0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick_s) begin
            shreg_r  <= {shreg_r[WIDTH-2:0], serial_i};
            bitcnt_r <= bitcnt_r + BW'(1);
            if (bitcnt_r == LAST_BIT) begin
              rx_data_r  <= {shreg_r[WIDTH-2:0], serial_i};
              rx_valid_r <= 1'b1;
              state_r    <= DONE;
            end
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready_o = ready_r;
  assign busy_o     = busy_r;
  assign rx_valid_o = rx_valid_r;
  assign rx_data_o  = rx_data_r;
  assign serial_o   = (state_r == SHIFT) & shreg_r[WIDTH-1];
  assign shift_o    = tick_s;

endmodule
